spi_host_cmd_master: RTL and testbench
======================================

Name: spi_host_cmd_master

Overview:
- Host-side SPI master that drives the systolic accelerator's SPI command interface.
- Accepts one command at a time from the local controller and frames it as a single SPI transaction (cs_n low, opcode byte, payload bytes, cs_n high).
- Fetches LOAD payload bytes from a local byte source and returns READ_RES and STATUS bytes to a local sink.
- Synchronizes the accelerator irq and tracks whether results are waiting.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period, >=1.
- SETUP_CYC, 4: clk cycles from cs_n falling to the first SCLK rising edge.
- GAP_CYC, 8: idle clk cycles between bytes with cs_n held low; gives the slave time to prepare tx data.
- HOLD_CYC, 4: clk cycles after the last SCLK falling edge before cs_n rises.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_op  in  3  0=LOAD_A, 1=LOAD_B, 2=START, 3=READ_RES, 4=STATUS
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready
- wr_req  out  1  one-cycle fetch request for a payload byte
- wr_idx  out  6  payload byte index being fetched
- wr_data  in  8  payload byte, valid on the clk cycle after wr_req
- rd_valid  out  1  one-cycle pulse, received byte available
- rd_idx  out  6  index of the received byte
- rd_data  out  8  received byte
- status_byte  out  8  last STATUS reply, held until the next STATUS command
- done  out  1  one-cycle pulse at end of a command
- cmd_err  out  1  pulses together with done for an invalid op
- busy  out  1  high whenever not in IDLE
- irq_in  in  1  accelerator irq, asynchronous
- irq_pending  out  1  sticky results-ready flag
- sclk  out  1  SPI clock, mode 0 (idle low)
- mosi  out  1  SPI data out, MSB first
- cs_n  out  1  SPI chip select, active low
- miso  in  1  SPI data in

Behaviour:
- Reset values: cs_n=1, sclk=0, mosi=0, wr_req=0, rd_valid=0, rd_idx=0, rd_data=0, done=0, cmd_err=0, busy=0, status_byte=0, irq_pending=0, irq sync flops=0, state IDLE (so cmd_ready=1).
- Opcode bytes: LOAD_A=0x10, LOAD_B=0x20, START=0x30, READ_RES=0x40, STATUS=0x50.
- Payload byte counts N (after the opcode byte): LOAD_A 32, LOAD_B 16, START 0, READ_RES 64, STATUS 1.
- LOAD byte order: wr_idx 0..N-1, each A element sent low byte then high byte. READ byte order: rd_idx 0..63, little-endian per 32-bit result.
- cmd_op 5..7: no SPI activity; done and cmd_err pulse on the cycle after acceptance; back to IDLE.
- States:
  - IDLE: on accept, latch op and go to SETUP.
  - SETUP: cs_n=0 for SETUP_CYC cycles, then load the opcode into the shift register and go to SHIFT.
  - SHIFT: 8 bits per byte. Each bit = CLK_DIV cycles sclk low, then CLK_DIV cycles sclk high. mosi changes only at bit start while sclk is low. miso is sampled on the clk where sclk rises. After bit 7's high phase, sclk returns low.
  - GAP: GAP_CYC cycles with cs_n=0, sclk=0.
    - If more bytes remain, go to FETCH for LOAD ops, else back to SHIFT (loading 0x00 for READ_RES/STATUS dummy bytes).
    - FETCH: wr_req pulses for 1 cycle, wr_data is captured on the next cycle, then SHIFT.
    - FETCH for payload byte 0 occurs after the opcode's GAP.
  - HOLD: entered after the last byte's high phase completes, skipping GAP. HOLD_CYC cycles, then cs_n=1, done pulses 1 cycle, and the block returns to IDLE on the next cycle.
- Received bytes:
  - The opcode byte's MISO is discarded.
  - For READ_RES, rd_valid pulses one cycle after the 8th sample of each payload byte, with rd_idx and rd_data.
  - For STATUS, the received byte goes to status_byte and rd_valid also pulses with rd_idx=0.
  - LOAD/START produce no rd_valid.
- Per-byte SPI time is 16*CLK_DIV clk cycles. Command latency, acceptance to done = 1 + SETUP_CYC + (N+1)*16*CLK_DIV + N*(GAP_CYC) + (fetch cycles 2*N for LOAD) + HOLD_CYC.
- IRQ handling:
  - irq_in passes through a 2-flop synchronizer.
  - A rising edge of the synchronized signal sets irq_pending.
  - Acceptance of READ_RES clears irq_pending; if a set and a clear occur on the same cycle, set wins.
- cmd_valid while busy is ignored; no queuing.
- Reset mid-transaction aborts immediately: cs_n=1, sclk=0. No done pulse; partial payload is not resumed.

Test Plan:
- STATUS, miso slave returns 0x08, defaults -> cs_n low once; mosi bytes 0x50,0x00; status_byte=0x08; rd_valid once (idx 0); done once; exactly 16 sclk rising edges.
- LOAD_B with source byte[i]=i+1 -> mosi stream 0x20,0x01..0x10; wr_req pulses 16 times, wr_idx 0..15; cs_n returns high HOLD_CYC cycles after the last sclk fall.
- READ_RES, slave model returning results_00=0x12345678, results_01=0xAABBCCDD -> rd_data idx0..7 = 78,56,34,12,DD,CC,BB,AA; 64 rd_valid pulses; 520 sclk rising edges.
- START, then irq_in asserted 50 cycles later -> mosi 0x30 only; irq_pending rises 2-3 cycles after irq_in; a following READ_RES acceptance clears it.
- cmd_op=6 -> no cs_n activity; done and cmd_err both pulse 1 cycle after acceptance.
- rst_n asserted mid-LOAD_A byte 10 -> cs_n=1 and sclk=0 asynchronously; cmd_ready=1 after release; no done pulse.

Source files
------------

// File: rtl/spi_host_cmd_master.sv
// Host-side SPI master: frames one accelerator command per transaction (opcode + payload),
// streams LOAD payload from a local source, returns READ_RES/STATUS bytes, tracks irq.
module spi_host_cmd_master #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned SETUP_CYC = 4,
    parameter int unsigned GAP_CYC   = 8,
    parameter int unsigned HOLD_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    output logic       cmd_ready,
    output logic       wr_req,
    output logic [5:0] wr_idx,
    input  logic [7:0] wr_data,
    output logic       rd_valid,
    output logic [5:0] rd_idx,
    output logic [7:0] rd_data,
    output logic [7:0] status_byte,
    output logic       done,
    output logic       cmd_err,
    output logic       busy,
    input  logic       irq_in,
    output logic       irq_pending,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    input  logic       miso
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_GAP, S_FETCH, S_HOLD} state_t;

    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_STATUS = 3'd4;

    function automatic logic [6:0] n_bytes(input logic [2:0] op);
        case (op)
            3'd0:    n_bytes = 7'd32;
            3'd1:    n_bytes = 7'd16;
            3'd3:    n_bytes = 7'd64;
            3'd4:    n_bytes = 7'd1;
            default: n_bytes = 7'd0;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, div_q, div_d;
    logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
    logic [2:0]  bit_q, bit_d, op_q, op_d;
    logic [6:0]  byte_q, byte_d;
    logic [7:0]  tx_q, tx_d, rx_q, rx_d;
    logic        wr_req_q, wr_req_d, rd_valid_q, rd_valid_d;
    logic [5:0]  wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [7:0]  rd_data_q, rd_data_d, status_q, status_d;
    logic        done_q, done_d, err_q, err_d;
    logic        irq_s1_q, irq_s2_q, irq_s3_q, irq_pend_q, irq_pend_d;
    logic        accept;
    logic [7:0]  opcode;

    assign accept = cmd_valid && (state_q == S_IDLE);
    assign opcode = {1'b0, op_q + 3'd1, 4'h0};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        bit_d      = bit_q;
        op_d       = op_q;
        byte_d     = byte_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        wr_req_d   = 1'b0;
        wr_idx_d   = wr_idx_q;
        rd_valid_d = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_data_d  = rd_data_q;
        status_d   = status_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        // A new synchronized irq edge beats a same-cycle clear from READ_RES acceptance
        irq_pend_d = (irq_s2_q & ~irq_s3_q) |
                     (irq_pend_q & ~(accept && cmd_op == OP_READ));

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = cmd_op;
                    if (cmd_op > OP_STATUS) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cs_n_d  = 1'b0;
                        cnt_d   = '0;
                        byte_d  = '0;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == 16'(SETUP_CYC - 1)) begin
                    state_d = S_SHIFT;
                    tx_d    = opcode;
                    mosi_d  = opcode[7];
                    div_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SHIFT: begin
                if (div_q == 16'(CLK_DIV - 1)) begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                        // byte_q counts the opcode as byte 0, so payload index is byte_q-1
                        if (bit_q == 3'd7 && byte_q != 7'd0 &&
                            (op_q == OP_READ || op_q == OP_STATUS)) begin
                            rd_valid_d = 1'b1;
                            rd_idx_d   = byte_q[5:0] - 6'd1;
                            rd_data_d  = {rx_q[6:0], miso};
                            if (op_q == OP_STATUS) status_d = {rx_q[6:0], miso};
                        end
                    end else begin
                        sclk_d = 1'b0;
                        if (bit_q == 3'd7) begin
                            cnt_d   = '0;
                            byte_d  = byte_q + 7'd1;
                            state_d = (byte_q == n_bytes(op_q)) ? S_HOLD : S_GAP;
                        end else begin
                            bit_d  = bit_q + 3'd1;
                            tx_d   = {tx_q[6:0], 1'b0};
                            mosi_d = tx_q[6];
                        end
                    end
                end else begin
                    div_d = div_q + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == 16'(GAP_CYC - 1)) begin
                    cnt_d = '0;
                    if (op_q <= 3'd1) begin
                        state_d  = S_FETCH;
                        wr_req_d = 1'b1;
                        wr_idx_d = byte_q[5:0] - 6'd1;
                    end else begin
                        state_d = S_SHIFT;
                        tx_d    = '0;
                        mosi_d  = 1'b0;
                        div_d   = '0;
                        bit_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_FETCH: begin
                if (cnt_q == 16'd0) begin
                    cnt_d = 16'd1;
                end else begin
                    state_d = S_SHIFT;
                    tx_d    = wr_data;
                    mosi_d  = wr_data[7];
                    div_d   = '0;
                    bit_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == 16'(HOLD_CYC - 1)) begin
                    state_d = S_IDLE;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            bit_q      <= '0;
            op_q       <= '0;
            byte_q     <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            wr_req_q   <= 1'b0;
            wr_idx_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_idx_q   <= '0;
            rd_data_q  <= '0;
            status_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irq_s1_q   <= 1'b0;
            irq_s2_q   <= 1'b0;
            irq_s3_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            bit_q      <= bit_d;
            op_q       <= op_d;
            byte_q     <= byte_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            wr_req_q   <= wr_req_d;
            wr_idx_q   <= wr_idx_d;
            rd_valid_q <= rd_valid_d;
            rd_idx_q   <= rd_idx_d;
            rd_data_q  <= rd_data_d;
            status_q   <= status_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irq_s1_q   <= irq_in;
            irq_s2_q   <= irq_s1_q;
            irq_s3_q   <= irq_s2_q;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign wr_req      = wr_req_q;
    assign wr_idx      = wr_idx_q;
    assign rd_valid    = rd_valid_q;
    assign rd_idx      = rd_idx_q;
    assign rd_data     = rd_data_q;
    assign status_byte = status_q;
    assign done        = done_q;
    assign cmd_err     = err_q;
    assign irq_pending = irq_pend_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign cs_n        = cs_n_q;

endmodule

// File: tb/tb_spi_host_cmd_master.sv
// Bench for spi_host_cmd_master: SPI slave model on the bus, scoreboard queues for
// mosi bytes, payload fetches and received bytes, plus latency/irq/reset checks.
`timescale 1ns/1ps
module tb_spi_host_cmd_master;

    localparam int CLK_DIV = 2, SETUP_CYC = 4, GAP_CYC = 8, HOLD_CYC = 4, PER = 10;

    logic       clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, irq_in = 1'b0, miso;
    logic [2:0] cmd_op = '0;
    logic [7:0] wr_data = '0;
    logic       cmd_ready, wr_req, rd_valid, done, cmd_err, busy, irq_pending, sclk, mosi, cs_n;
    logic [5:0] wr_idx, rd_idx;
    logic [7:0] rd_data, status_byte;

    spi_host_cmd_master #(.CLK_DIV(CLK_DIV), .SETUP_CYC(SETUP_CYC), .GAP_CYC(GAP_CYC),
                          .HOLD_CYC(HOLD_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .wr_req(wr_req), .wr_idx(wr_idx), .wr_data(wr_data), .rd_valid(rd_valid),
        .rd_idx(rd_idx), .rd_data(rd_data), .status_byte(status_byte), .done(done),
        .cmd_err(cmd_err), .busy(busy), .irq_in(irq_in), .irq_pending(irq_pending),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
    );

    always #(PER/2) clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [7:0]  exp_mosi[$], obs_mosi[$];
    logic [5:0]  exp_wr[$],   obs_wr[$];
    logic [13:0] exp_rd[$],   obs_rd[$];
    logic [7:0]  rdmem [64];
    logic [2:0]  cur_op = '0;
    int  n_sclk_rise = 0, n_csn_fall = 0, n_done = 0, n_err = 0;
    time t_last_fall = 0, t_cs_rise = 0;

    // SPI slave model: mode 0, captures mosi on sclk rise, updates miso on sclk fall
    logic       p_cs = 1'b1, p_sclk = 1'b0;
    logic [7:0] rxsh = '0, slv_tx = '0, slv_op = '0;
    int         bitpos = 0, byte_n = 0;
    assign miso = slv_tx[3'(7 - bitpos)];

    always @(cs_n or sclk) begin
        if (p_cs === 1'b1 && cs_n === 1'b0) begin
            n_csn_fall++;
            bitpos = 0; byte_n = 0; slv_tx = '0;
        end
        if (p_cs === 1'b0 && cs_n === 1'b1) t_cs_rise = $time;
        if (p_sclk === 1'b0 && sclk === 1'b1) begin
            n_sclk_rise++;
            if (cs_n === 1'b0) begin
                rxsh = {rxsh[6:0], mosi};
                bitpos++;
                if (bitpos == 8) begin
                    obs_mosi.push_back(rxsh);
                    if (byte_n == 0) slv_op = rxsh;
                end
            end
        end
        if (p_sclk === 1'b1 && sclk === 1'b0) begin
            t_last_fall = $time;
            if (cs_n === 1'b0 && bitpos == 8) begin
                bitpos = 0;
                byte_n++;
                if (slv_op == 8'h50 && byte_n == 1) slv_tx = 8'h08;
                else if (slv_op == 8'h40 && byte_n <= 64) slv_tx = rdmem[byte_n - 1];
                else slv_tx = '0;
            end
        end
        p_cs = cs_n; p_sclk = sclk;
    end

    function automatic logic [7:0] src_byte(input logic [2:0] op, input logic [5:0] idx);
        return (op == 3'd0) ? 8'(idx * 5 + 3) : 8'(idx + 1);
    endfunction

    // Local byte source / sink monitors
    always @(negedge clk) begin
        if (wr_req === 1'b1) begin
            obs_wr.push_back(wr_idx);
            wr_data = src_byte(cur_op, wr_idx);
        end
        if (rd_valid === 1'b1) obs_rd.push_back({rd_idx, rd_data});
        if (done === 1'b1) n_done++;
        if (cmd_err === 1'b1) n_err++;
    end

    initial begin
        #(200000 * PER);
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    task automatic clear_sb();
        exp_mosi.delete(); obs_mosi.delete();
        exp_wr.delete();   obs_wr.delete();
        exp_rd.delete();   obs_rd.delete();
    endtask

    // Issue one command; lat counts cycles from the accepting cycle to the done cycle
    task automatic run_cmd(input logic [2:0] op, input int budget,
                           output int lat, output logic err, output logic pend0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        pend0 = irq_pending;
        lat = -1; err = 1'bx;
        for (int i = 1; i <= budget; i++) begin
            if (done === 1'b1) begin
                lat = i; err = cmd_err;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({cs_n, sclk, mosi, busy, cmd_ready} !== 5'b10001) begin
            n_bad++; $display("FAIL reset_in: {cs_n,sclk,mosi,busy,ready} got %b expected 10001",
                              {cs_n, sclk, mosi, busy, cmd_ready});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({wr_req, rd_valid, done, cmd_err, irq_pending} !== 5'b0) begin
            n_bad++; $display("FAIL reset_pulses: got %b expected 00000",
                              {wr_req, rd_valid, done, cmd_err, irq_pending});
        end
        n_cmp++;
        if ({rd_idx, rd_data, status_byte} !== 22'h0) begin
            n_bad++; $display("FAIL reset_data: got %h expected 0", {rd_idx, rd_data, status_byte});
        end
        n_cmp++;
        if ({cs_n, sclk, cmd_ready} !== 3'b101) begin
            n_bad++; $display("FAIL reset_after: {cs_n,sclk,ready} got %b expected 101",
                              {cs_n, sclk, cmd_ready});
        end
    endtask

    task automatic test_status();
        int lat, s0, c0, d0; logic err, p0;
        clear_sb();
        exp_mosi.push_back(8'h50); exp_mosi.push_back(8'h00);
        exp_rd.push_back({6'd0, 8'h08});
        s0 = n_sclk_rise; c0 = n_csn_fall; d0 = n_done;
        run_cmd(3'd4, 1000, lat, err, p0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (lat !== 81) begin n_bad++; $display("FAIL status_latency: got %0d expected 81", lat); end
        n_cmp++;
        if (status_byte !== 8'h08) begin
            n_bad++; $display("FAIL status_byte: got %h expected 08", status_byte);
        end
        n_cmp++;
        if (n_sclk_rise - s0 !== 16) begin
            n_bad++; $display("FAIL status_sclk: got %0d expected 16", n_sclk_rise - s0);
        end
        n_cmp++;
        if (n_csn_fall - c0 !== 1 || n_done - d0 !== 1) begin
            n_bad++; $display("FAIL status_cs_done: cs falls %0d dones %0d expected 1 1",
                              n_csn_fall - c0, n_done - d0);
        end
        n_cmp++;
        if (obs_mosi.size() != exp_mosi.size() || obs_rd.size() != exp_rd.size()) begin
            n_bad++; $display("FAIL status_counts: mosi %0d rd %0d expected %0d %0d",
                              obs_mosi.size(), obs_rd.size(), exp_mosi.size(), exp_rd.size());
        end
        while (exp_mosi.size() > 0 && obs_mosi.size() > 0) begin
            logic [7:0] o, e;
            o = obs_mosi.pop_front(); e = exp_mosi.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL status_mosi: got %h expected %h", o, e); end
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            logic [13:0] o, e;
            o = obs_rd.pop_front(); e = exp_rd.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL status_rd: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_load_b();
        int lat, s0; logic err, p0;
        clear_sb();
        cur_op = 3'd1;
        exp_mosi.push_back(8'h20);
        for (int i = 0; i < 16; i++) begin
            exp_mosi.push_back(8'(i + 1));
            exp_wr.push_back(6'(i));
        end
        s0 = n_sclk_rise;
        run_cmd(3'd1, 5000, lat, err, p0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (lat !== 713) begin n_bad++; $display("FAIL loadb_latency: got %0d expected 713", lat); end
        n_cmp++;
        if (n_sclk_rise - s0 !== 136) begin
            n_bad++; $display("FAIL loadb_sclk: got %0d expected 136", n_sclk_rise - s0);
        end
        n_cmp++;
        if (t_cs_rise - t_last_fall !== time'(HOLD_CYC * PER)) begin
            n_bad++; $display("FAIL loadb_hold: got %0t expected %0d", t_cs_rise - t_last_fall,
                              HOLD_CYC * PER);
        end
        n_cmp++;
        if (obs_mosi.size() != 17 || obs_wr.size() != 16 || obs_rd.size() != 0) begin
            n_bad++; $display("FAIL loadb_counts: mosi %0d wr %0d rd %0d expected 17 16 0",
                              obs_mosi.size(), obs_wr.size(), obs_rd.size());
        end
        while (exp_mosi.size() > 0 && obs_mosi.size() > 0) begin
            logic [7:0] o, e;
            o = obs_mosi.pop_front(); e = exp_mosi.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL loadb_mosi: got %h expected %h", o, e); end
        end
        while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
            logic [5:0] o, e;
            o = obs_wr.pop_front(); e = exp_wr.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL loadb_wr_idx: got %0d expected %0d", o, e); end
        end
    endtask

    task automatic test_start_irq();
        int lat, k; logic err, p0;
        clear_sb();
        exp_mosi.push_back(8'h30);
        run_cmd(3'd2, 500, lat, err, p0);
        n_cmp++;
        if (lat !== 41) begin n_bad++; $display("FAIL start_latency: got %0d expected 41", lat); end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (obs_mosi.size() != 1 || (obs_mosi.size() == 1 && obs_mosi[0] !== exp_mosi[0])) begin
            n_bad++; $display("FAIL start_mosi: %0d bytes first %h expected 1 byte 30",
                              obs_mosi.size(), obs_mosi.size() > 0 ? obs_mosi[0] : 8'hxx);
        end
        n_cmp++;
        if (irq_pending !== 1'b0) begin
            n_bad++; $display("FAIL irq_idle: got %b expected 0", irq_pending);
        end
        repeat (6) @(negedge clk);
        #3 irq_in = 1'b1;
        k = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (irq_pending === 1'b1) begin k = i; break; end
        end
        n_cmp++;
        if (k < 2 || k > 3) begin
            n_bad++; $display("FAIL irq_sync_delay: got %0d cycles expected 2..3", k);
        end
    endtask

    task automatic test_read_res();
        int lat, s0; logic err, p0;
        clear_sb();
        exp_mosi.push_back(8'h40);
        for (int i = 0; i < 64; i++) begin
            exp_mosi.push_back(8'h00);
            exp_rd.push_back({6'(i), rdmem[i]});
        end
        s0 = n_sclk_rise;
        n_cmp++;
        if (irq_pending !== 1'b1) begin
            n_bad++; $display("FAIL irq_before_read: got %b expected 1", irq_pending);
        end
        run_cmd(3'd3, 6000, lat, err, p0);
        irq_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (p0 !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b expected 0", p0); end
        n_cmp++;
        if (lat !== 2601) begin n_bad++; $display("FAIL read_latency: got %0d expected 2601", lat); end
        n_cmp++;
        if (n_sclk_rise - s0 !== 520) begin
            n_bad++; $display("FAIL read_sclk: got %0d expected 520", n_sclk_rise - s0);
        end
        n_cmp++;
        if (obs_rd.size() != 64 || obs_mosi.size() != 65) begin
            n_bad++; $display("FAIL read_counts: rd %0d mosi %0d expected 64 65",
                              obs_rd.size(), obs_mosi.size());
        end
        while (exp_rd.size() > 0 && obs_rd.size() > 0) begin
            logic [13:0] o, e;
            o = obs_rd.pop_front(); e = exp_rd.pop_front(); n_cmp++;
            if (o !== e) begin
                n_bad++; $display("FAIL read_rd: idx/data got %0d/%h expected %0d/%h",
                                  o[13:8], o[7:0], e[13:8], e[7:0]);
            end
        end
        while (exp_mosi.size() > 0 && obs_mosi.size() > 0) begin
            logic [7:0] o, e;
            o = obs_mosi.pop_front(); e = exp_mosi.pop_front(); n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL read_mosi: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_invalid_op();
        int lat, c0, e0; logic err, p0;
        c0 = n_csn_fall; e0 = n_err;
        run_cmd(3'd6, 50, lat, err, p0);
        n_cmp++;
        if (lat !== 1 || err !== 1'b1) begin
            n_bad++; $display("FAIL invalid_done_err: lat %0d err %b expected 1 1", lat, err);
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (n_csn_fall - c0 !== 0 || n_err - e0 !== 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL invalid_quiet: cs falls %0d errs %0d busy %b expected 0 1 0",
                              n_csn_fall - c0, n_err - e0, busy);
        end
    endtask

    task automatic test_reset_mid_load();
        int d0; logic hit;
        cur_op = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (wr_req === 1'b1 && wr_idx === 6'd10) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++;
        if (hit !== 1'b1) begin n_bad++; $display("FAIL mid_reach_byte10: got %b expected 1", hit); end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (cs_n !== 1'b0) begin n_bad++; $display("FAIL mid_active: cs_n got %b expected 0", cs_n); end
        d0 = n_done;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cs_n, sclk, busy} !== 3'b100) begin
            n_bad++; $display("FAIL mid_async_reset: {cs_n,sclk,busy} got %b expected 100",
                              {cs_n, sclk, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++; $display("FAIL mid_ready: got %b expected 1", cmd_ready);
        end
        repeat (100) @(negedge clk);
        n_cmp++;
        if (n_done - d0 !== 0 || cs_n !== 1'b1) begin
            n_bad++; $display("FAIL mid_no_done: dones %0d cs_n %b expected 0 1", n_done - d0, cs_n);
        end
    endtask

    initial begin
        for (int w = 0; w < 16; w++) begin
            logic [31:0] word;
            word = (w == 0) ? 32'h12345678 : (w == 1) ? 32'hAABBCCDD :
                   ({4{8'(w * 17)}} ^ 32'h01020304);
            for (int b = 0; b < 4; b++) rdmem[w*4 + b] = word[b*8 +: 8];
        end
        test_reset();
        test_status();
        test_load_b();
        test_start_irq();
        test_read_res();
        test_invalid_op();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
